// File: rtl/btn_conditioner.sv
// ============================================================================
//  Module   : btn_conditioner
//  Purpose  : Synchronizes, debounces and decodes raw push-button levels into
//             level, press, release, long-press and auto-repeat events.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module btn_conditioner #(
    parameter int N_BTN         = 3,
    parameter int DB_CYCLES     = 4,
    parameter int HOLD_CYCLES   = 16,
    parameter int REPEAT_CYCLES = 8,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] press_pulse,
    output logic [N_BTN-1:0] release_pulse,
    output logic [N_BTN-1:0] hold_pulse,
    output logic [N_BTN-1:0] repeat_pulse
);

    // Terminal counts are compared one below the target so the event and the
    // counter clear land on the same edge as the count reaching the target.
    localparam logic [CNT_W-1:0] c_db_last   = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_hold_last = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_rep_last  = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_cnt_max   = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_PRESSED = 2'b01,
        ST_HELD    = 2'b10
    } state_t;

    // Plain two-flop synchronizer; nothing may sit between the stages.
    logic [N_BTN-1:0] sync1_q;
    logic [N_BTN-1:0] sync2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
        end
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        state_t           state_q,    state_d;
        logic [CNT_W-1:0] db_cnt_q,   db_cnt_d;
        logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
        logic             level_q,    level_d;
        logic             press_q,    press_d;
        logic             release_q,  release_d;
        logic             hold_q,     hold_d;
        logic             repeat_q,   repeat_d;

        always_comb begin
            db_cnt_d = db_cnt_q;
            level_d  = level_q;
            if (sync2_q[i] == level_q) begin
                db_cnt_d = '0;
            end else if (db_cnt_q == c_db_last) begin
                level_d  = ~level_q;
                db_cnt_d = '0;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end

        // Decodes on the next debounced level so every pulse coincides with
        // the first cycle of the new level.
        always_comb begin
            state_d    = state_q;
            hold_cnt_d = hold_cnt_q;
            press_d    = 1'b0;
            release_d  = 1'b0;
            hold_d     = 1'b0;
            repeat_d   = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (level_d) begin
                        state_d    = ST_PRESSED;
                        press_d    = 1'b1;
                        hold_cnt_d = '0;
                    end
                end
                ST_PRESSED: begin
                    if (!level_d) begin
                        state_d    = ST_IDLE;
                        release_d  = 1'b1;
                        hold_cnt_d = '0;
                    end else if (hold_cnt_q == c_hold_last) begin
                        state_d    = ST_HELD;
                        hold_d     = 1'b1;
                        hold_cnt_d = '0;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end
                ST_HELD: begin
                    if (!level_d) begin
                        state_d    = ST_IDLE;
                        release_d  = 1'b1;
                        hold_cnt_d = '0;
                    end else if (REPEAT_CYCLES == 0) begin
                        if (hold_cnt_q != c_cnt_max) begin
                            hold_cnt_d = hold_cnt_q + 1'b1;
                        end
                    end else if (hold_cnt_q == c_rep_last) begin
                        repeat_d   = 1'b1;
                        hold_cnt_d = '0;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d    = ST_IDLE;
                    hold_cnt_d = '0;
                end
            endcase
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q    <= ST_IDLE;
                db_cnt_q   <= '0;
                hold_cnt_q <= '0;
                level_q    <= 1'b0;
                press_q    <= 1'b0;
                release_q  <= 1'b0;
                hold_q     <= 1'b0;
                repeat_q   <= 1'b0;
            end else begin
                state_q    <= state_d;
                db_cnt_q   <= db_cnt_d;
                hold_cnt_q <= hold_cnt_d;
                level_q    <= level_d;
                press_q    <= press_d;
                release_q  <= release_d;
                hold_q     <= hold_d;
                repeat_q   <= repeat_d;
            end
        end

        assign btn_level[i]     = level_q;
        assign press_pulse[i]   = press_q;
        assign release_pulse[i] = release_q;
        assign hold_pulse[i]    = hold_q;
        assign repeat_pulse[i]  = repeat_q;
    end

endmodule

`default_nettype wire

// File: tb/tb_btn_conditioner.sv
// ============================================================================
//  Module   : tb_btn_conditioner
//  Purpose  : Self-checking bench for btn_conditioner with an event scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_btn_conditioner;

    localparam int N_BTN = 3;
    localparam int DB    = 4;
    localparam int HOLD  = 16;
    localparam int REP   = 8;
    localparam int LAT   = DB + 2;

    localparam int K_PRESS   = 0;
    localparam int K_RELEASE = 1;
    localparam int K_HOLD    = 2;
    localparam int K_REPEAT  = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N_BTN-1:0] btn = '0;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] press_pulse;
    logic [N_BTN-1:0] release_pulse;
    logic [N_BTN-1:0] hold_pulse;
    logic [N_BTN-1:0] repeat_pulse;

    int cyc   = 0;
    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        int cyc;
        int kind;
        int b;
    } ev_t;

    ev_t exp_q[$];

    btn_conditioner #(
        .N_BTN        (N_BTN),
        .DB_CYCLES    (DB),
        .HOLD_CYCLES  (HOLD),
        .REPEAT_CYCLES(REP),
        .CNT_W        (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn          (btn),
        .btn_level    (btn_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .hold_pulse   (hold_pulse),
        .repeat_pulse (repeat_pulse)
    );

    always #15 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [N_BTN-1:0] pv(int k);
        case (k)
            K_PRESS:   return press_pulse;
            K_RELEASE: return release_pulse;
            K_HOLD:    return hold_pulse;
            default:   return repeat_pulse;
        endcase
    endfunction

    task automatic push(input int c, input int k, input int b);
        ev_t e;
        e.cyc  = c;
        e.kind = k;
        e.b    = b;
        exp_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Scoreboard: every observed pulse must match a queued expectation for
    // this cycle; expectations whose cycle has passed are reported missing.
    task automatic monitor();
        forever begin
            @(negedge clk);
            if (!rst) begin
                for (int b = 0; b < N_BTN; b++) begin
                    int npulse;
                    npulse = 0;
                    for (int k = 0; k < 4; k++) begin
                        logic [N_BTN-1:0] v;
                        int idx;
                        v   = pv(k);
                        idx = -1;
                        if (v[b]) begin
                            npulse++;
                            foreach (exp_q[j])
                                if (exp_q[j].cyc == cyc && exp_q[j].kind == k && exp_q[j].b == b)
                                    idx = j;
                            n_cmp++;
                            if (idx < 0) begin
                                n_err++;
                                $display("FAIL sb_unexpected kind=%0d bit=%0d cyc=%0d: got 1 expected 0", k, b, cyc);
                            end else begin
                                exp_q.delete(idx);
                            end
                        end
                    end
                    if (npulse > 1) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL exclusive bit=%0d cyc=%0d: got %0d pulses expected <=1", b, cyc, npulse);
                    end
                end
                for (int j = exp_q.size() - 1; j >= 0; j--) begin
                    if (exp_q[j].cyc <= cyc) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL sb_missed kind=%0d bit=%0d cyc=%0d: got 0 expected 1", exp_q[j].kind, exp_q[j].b, exp_q[j].cyc);
                        exp_q.delete(j);
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        step(2);
        n_cmp++;
        if ({btn_level, press_pulse, release_pulse, hold_pulse, repeat_pulse} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {btn_level, press_pulse, release_pulse, hold_pulse, repeat_pulse});
        end
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            n_cmp++;
            if ({btn_level, press_pulse, release_pulse, hold_pulse, repeat_pulse} !== '0) begin
                n_err++;
                $display("FAIL idle_outputs cyc=%0d: got %h expected 0", cyc,
                         {btn_level, press_pulse, release_pulse, hold_pulse, repeat_pulse});
            end
        end
    endtask

    task automatic test_glitch();
        for (int i = 0; i < 9; i++) begin
            btn[0] = 1'b1;
            #20;
            btn[0] = 1'b0;
            #20;
        end
        step(1);
        for (int i = 0; i < 8; i++) begin
            step(1);
            n_cmp++;
            if (btn_level !== '0) begin
                n_err++;
                $display("FAIL glitch_level cyc=%0d: got %b expected 000", cyc, btn_level);
            end
        end
    endtask

    task automatic test_press_release();
        int c;
        c = cyc;
        btn[0] = 1'b1;
        push(c + LAT, K_PRESS, 0);
        step(LAT - 1);
        n_cmp++;
        if (btn_level[0] !== 1'b0) begin
            n_err++;
            $display("FAIL press_early_level: got %b expected 0", btn_level[0]);
        end
        step(1);
        n_cmp++;
        if (btn_level[0] !== 1'b1 || press_pulse[0] !== 1'b1) begin
            n_err++;
            $display("FAIL press_latency: got level=%b pulse=%b expected 1/1", btn_level[0], press_pulse[0]);
        end
        step(10 - LAT);
        c = cyc;
        btn[0] = 1'b0;
        push(c + LAT, K_RELEASE, 0);
        step(LAT - 1);
        n_cmp++;
        if (btn_level[0] !== 1'b1) begin
            n_err++;
            $display("FAIL release_early_level: got %b expected 1", btn_level[0]);
        end
        step(1);
        n_cmp++;
        if (btn_level[0] !== 1'b0 || release_pulse[0] !== 1'b1) begin
            n_err++;
            $display("FAIL release_latency: got level=%b pulse=%b expected 0/1", btn_level[0], release_pulse[0]);
        end
        step(6);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL press_release_pending: got %0d expected 0", exp_q.size());
        end
    endtask

    task automatic test_bounce();
        logic [5:0] pat;
        int c;
        pat = 6'b101101;
        c   = cyc;
        for (int i = 0; i < 6; i++) begin
            c = cyc;
            btn[1] = pat[i];
            step(1);
        end
        push(c + LAT, K_PRESS, 1);
        step(9);
        c = cyc;
        btn[1] = 1'b0;
        push(c + LAT, K_RELEASE, 1);
        step(LAT + 4);
        n_cmp++;
        if (exp_q.size() != 0 || btn_level[1] !== 1'b0) begin
            n_err++;
            $display("FAIL bounce_pending: got %0d/%b expected 0/0", exp_q.size(), btn_level[1]);
        end
    endtask

    task automatic test_hold_repeat();
        int c;
        c = cyc;
        btn[2] = 1'b1;
        push(c + LAT, K_PRESS, 2);
        push(c + LAT + HOLD, K_HOLD, 2);
        for (int r = 1; c + LAT + HOLD + r * REP < c + 60 + LAT; r++)
            push(c + LAT + HOLD + r * REP, K_REPEAT, 2);
        push(c + 60 + LAT, K_RELEASE, 2);
        step(30);
        n_cmp++;
        if (btn_level[2] !== 1'b1) begin
            n_err++;
            $display("FAIL hold_level: got %b expected 1", btn_level[2]);
        end
        step(30);
        btn[2] = 1'b0;
        step(LAT + 3 * REP);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL hold_pending: got %0d expected 0", exp_q.size());
        end
    endtask

    task automatic test_simultaneous();
        int c;
        c = cyc;
        btn = 3'b101;
        push(c + LAT, K_PRESS, 0);
        push(c + LAT, K_PRESS, 2);
        step(8);
        c = cyc;
        btn = 3'b000;
        push(c + LAT, K_RELEASE, 0);
        push(c + LAT, K_RELEASE, 2);
        step(LAT + 4);
        n_cmp++;
        if (exp_q.size() != 0 || btn_level !== 3'b000) begin
            n_err++;
            $display("FAIL simul_pending: got %0d/%b expected 0/000", exp_q.size(), btn_level);
        end
    endtask

    task automatic test_reset_in_held();
        int c;
        c = cyc;
        btn[0] = 1'b1;
        push(c + LAT, K_PRESS, 0);
        push(c + LAT + HOLD, K_HOLD, 0);
        step(LAT + HOLD + 3);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL held_pending: got %0d expected 0", exp_q.size());
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({btn_level, press_pulse, release_pulse, hold_pulse, repeat_pulse} !== '0) begin
            n_err++;
            $display("FAIL async_reset: got %h expected 0",
                     {btn_level, press_pulse, release_pulse, hold_pulse, repeat_pulse});
        end
        step(2);
        c = cyc;
        rst = 1'b0;
        push(c + LAT, K_PRESS, 0);
        step(LAT - 1);
        n_cmp++;
        if (btn_level[0] !== 1'b0) begin
            n_err++;
            $display("FAIL post_reset_early: got %b expected 0", btn_level[0]);
        end
        step(1);
        n_cmp++;
        if (btn_level[0] !== 1'b1 || press_pulse[0] !== 1'b1) begin
            n_err++;
            $display("FAIL post_reset_press: got level=%b pulse=%b expected 1/1", btn_level[0], press_pulse[0]);
        end
        step(3);
        c = cyc;
        btn[0] = 1'b0;
        push(c + LAT, K_RELEASE, 0);
        step(LAT + 4);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL post_reset_pending: got %0d expected 0", exp_q.size());
        end
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_glitch();
        test_press_release();
        test_bounce();
        test_hold_repeat();
        test_simultaneous();
        test_reset_in_held();
        step(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
- Input-side receiver for the calculator's push-button interface.
- Takes raw, asynchronous, bouncy `btn` levels from the board or stimulus and delivers clean, clock-synchronous events to the calculator datapath.
- Events delivered: debounced level, one-cycle press pulse, one-cycle release pulse, one long-press pulse and auto-repeat pulses.
- Sits between the top-level `btn` pins and the calculator's operand/operator entry FSM, one instance per button bus.

Parameters:
- N_BTN, 3: number of independent buttons.
- DB_CYCLES, 4: consecutive stable synchronized samples required to change debounced level (>=1).
- HOLD_CYCLES, 16: cycles the debounced level must stay high before `hold_pulse` fires (> DB_CYCLES).
- REPEAT_CYCLES, 8: period of `repeat_pulse` after hold; 0 disables repeat.
- CNT_W, 8: width of the internal debounce/hold counters; must hold max(DB_CYCLES, HOLD_CYCLES, REPEAT_CYCLES).

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- btn  input  N_BTN  raw button levels, asynchronous to clk, 1 = pressed.
- btn_level  output  N_BTN  debounced, synchronized level per button.
- press_pulse  output  N_BTN  one-cycle pulse on debounced 0->1.
- release_pulse  output  N_BTN  one-cycle pulse on debounced 1->0.
- hold_pulse  output  N_BTN  one-cycle pulse when press lasts HOLD_CYCLES.
- repeat_pulse  output  N_BTN  one-cycle pulse every REPEAT_CYCLES after hold while still pressed.

Behaviour:
- Reset (async assert, sync release):
  - All outputs 0; synchronizer flops 0; counters 0; every per-button FSM in IDLE.
  - Reset mid-press drops `btn_level` immediately with no `release_pulse`.
  - After reset, a button already held produces a normal press after full latency.
- Synchronizer: 2 flops per bit. `sync[i]` is the second flop. No logic between the flops.
- Debounce, per bit:
  - `db_cnt` increments each cycle `sync[i]` != `btn_level[i]`.
  - `db_cnt` clears on any cycle they agree.
  - When `db_cnt` reaches DB_CYCLES, `btn_level[i]` toggles and `db_cnt` clears in the same edge.
  - Latency: raw change stable before edge k -> `btn_level` changes after edge k+1+DB_CYCLES (DB_CYCLES+2 cycles).
  - A glitch shorter than DB_CYCLES synchronized cycles produces no output activity.
- Per-button FSM, states IDLE, PRESSED, HELD:
  - IDLE -> PRESSED on debounced rise: `press_pulse` high in the first cycle `btn_level` is high; `hold_cnt` cleared.
  - In PRESSED, `hold_cnt` increments each cycle. At HOLD_CYCLES: -> HELD, `hold_pulse` one cycle, `hold_cnt` cleared.
  - In HELD with REPEAT_CYCLES>0, `hold_cnt` counts. At REPEAT_CYCLES: `repeat_pulse` one cycle, `hold_cnt` cleared, stay in HELD.
  - In HELD with REPEAT_CYCLES=0, `hold_cnt` saturates and no repeats are produced.
  - PRESSED or HELD -> IDLE on debounced fall: `release_pulse` high in the first cycle `btn_level` is low. Pending hold/repeat is cancelled.
- `press_pulse`, `release_pulse`, `hold_pulse` and `repeat_pulse` are registered and mutually exclusive per bit.
- Counters never wrap: they clear or saturate as above.
- Buttons are fully independent. Simultaneous presses on multiple bits yield simultaneous pulses with no priority or masking.

Test Plan (clk period 30 ns, default parameters):
- Reset then `btn`=000 for 20 cycles -> all outputs 0 throughout.
- `btn[0]` high for 20 ns (sub-cycle glitch), repeated 9 times 20 ns apart -> `btn_level`, `press_pulse` never assert.
- `btn[0]` held high 10 cycles from edge k -> `press_pulse[0]`=1 exactly in cycle k+6, `btn_level[0]`=1 from k+6. Release -> `release_pulse[0]` 6 cycles after the release edge, single cycle.
- Bounce: `btn[1]` toggles 1,0,1,1,0,1 then holds high -> no pulse until 4 consecutive stable synchronized samples; exactly one `press_pulse[1]`.
- `btn[2]` held 60 cycles -> `press_pulse`, then `hold_pulse` 16 cycles later, then `repeat_pulse` every 8 cycles. After release: one `release_pulse`, no further repeats.
- Assert `rst` while `btn[0]` is in HELD -> all outputs 0 immediately. Deassert with `btn[0]` still high -> fresh `press_pulse` after 6 cycles, no `release_pulse`.
